// File: rtl/systolic_pe_param_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pe_param_pkg
// Shared definitions for the parameterised spiking systolic processing element:
//   - default lane count, spike width, weight width and partial-sum width
//   - bank_state_e : weight shadow-bank state (SH_EMPTY / SH_FULL)
//   - lane_lsb()   : bit offset of lane t inside a packed multi-lane bus
// -----------------------------------------------------------------------------
package systolic_pe_param_pkg;

    localparam int DEF_TIME_STEPS = 4;
    localparam int DEF_SPIKE_W    = 2;
    localparam int DEF_WEIGHT_W   = 8;
    localparam int DEF_LANE_W     = 20;

    typedef enum logic {
        SH_EMPTY = 1'b0,
        SH_FULL  = 1'b1
    } bank_state_e;

    // Lane t of a packed bus with lanes of 'width' bits starts at bit t*width.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/systolic_pe_param_lane_mac.sv
// -----------------------------------------------------------------------------
// systolic_lane_mac
// One time-step lane of the PE: a product register (unsigned spike times
// signed weight, built from one shift-and-add term per spike bit) followed by
// a registered add with the partial sum arriving from the PE above.
//
// Build option: SYSTOLIC_PE_SAT_EN defined -> the lane sum saturates to the
// signed LANE_W range; undefined -> the lane sum wraps modulo 2^LANE_W.
//
// Ports:
//   s_clk, s_rst : clock, synchronous active-high reset
//   capture      : load the product register this edge (input beat valid)
//   spike        : unsigned activation for this lane
//   weight       : signed active weight
//   update       : register the lane sum this edge (forwarded beat valid)
//   psum_in      : signed partial sum from the PE above
//   psum_out     : registered signed partial sum for this lane
// -----------------------------------------------------------------------------
module systolic_lane_mac #(
    parameter int SPIKE_W  = 2,
    parameter int WEIGHT_W = 8,
    parameter int LANE_W   = 20
) (
    input  logic                s_clk,
    input  logic                s_rst,
    input  logic                capture,
    input  logic [SPIKE_W-1:0]  spike,
    input  logic [WEIGHT_W-1:0] weight,
    input  logic                update,
    input  logic [LANE_W-1:0]   psum_in,
    output logic [LANE_W-1:0]   psum_out
);

    // (2^SPIKE_W - 1) * (-2^(WEIGHT_W-1)) always fits in WEIGHT_W+SPIKE_W bits.
    localparam int PROD_W = WEIGHT_W + SPIKE_W;

    logic [PROD_W-1:0] weight_ext;
    logic [PROD_W-1:0] term [SPIKE_W];
    logic [PROD_W-1:0] product_sum;
    logic [PROD_W-1:0] prod_q, prod_d;
    logic [LANE_W-1:0] prod_ext;
    logic [LANE_W-1:0] sum_lane;
    logic [LANE_W-1:0] psum_q, psum_d;

    assign weight_ext = {{SPIKE_W{weight[WEIGHT_W-1]}}, weight};

    // One partial product per spike bit: the weight shifted by the bit index,
    // kept in two's complement so the plain sum is the signed product.
    genvar gi;
    generate
        for (gi = 0; gi < SPIKE_W; gi++) begin : g_term
            assign term[gi] = spike[gi] ? (weight_ext << gi) : '0;
        end
    endgenerate

    always_comb begin
        product_sum = '0;
        for (int b = 0; b < SPIKE_W; b++) begin
            product_sum = product_sum + term[b];
        end
    end

    always_comb begin
        prod_d = prod_q;
        if (capture) begin
            prod_d = product_sum;
        end
    end

    assign prod_ext = {{(LANE_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};

`ifdef SYSTOLIC_PE_SAT_EN
    logic [LANE_W:0] sum_wide;

    // One guard bit: overflow shows as the guard bit differing from the
    // lane sign bit; the guard bit then gives the true sign.
    assign sum_wide = {prod_ext[LANE_W-1], prod_ext} + {psum_in[LANE_W-1], psum_in};

    always_comb begin
        sum_lane = sum_wide[LANE_W-1:0];
        if (sum_wide[LANE_W] != sum_wide[LANE_W-1]) begin
            sum_lane = sum_wide[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}}
                                        : {1'b0, {(LANE_W-1){1'b1}}};
        end
    end
`else
    assign sum_lane = prod_ext + psum_in;
`endif

    always_comb begin
        psum_d = psum_q;
        if (update) begin
            psum_d = sum_lane;
        end
    end

    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            prod_q <= '0;
            psum_q <= '0;
        end else begin
            prod_q <= prod_d;
            psum_q <= psum_d;
        end
    end

    assign psum_out = psum_q;

endmodule

// File: rtl/systolic_pe_param.sv
// -----------------------------------------------------------------------------
// systolic_pe_param
// Weight-stationary systolic PE for multi-time-step spiking activations.
// A double-buffered weight (shadow + active) is loaded through a small
// handshake; activations are forwarded right with one cycle of delay and
// each time-step lane accumulates spike*weight onto the partial sum from
// the PE above, two cycles after the input beat.
//
// Build option: SYSTOLIC_PE_SAT_EN (saturating lane sums; wrap otherwise).
//
// Ports:
//   s_clk, s_rst      : clock, synchronous active-high reset
//   w_load_valid/data : write a signed weight into the shadow bank
//   w_load_ready      : shadow bank empty (held low while reset is asserted)
//   w_swap            : promote shadow bank to active
//   w_active_ok       : active bank holds a loaded weight
//   in_valid/in_data  : packed activations, lane t at [t*SPIKE_W +: SPIKE_W]
//   out_valid/out_data: activations forwarded to the right neighbour
//   in_psum           : packed partial sums from the PE above
//   out_psum_valid/out_psum : packed partial sums to the PE below
// -----------------------------------------------------------------------------
module systolic_pe_param
    import systolic_pe_param_pkg::*;
#(
    parameter int TIME_STEPS = DEF_TIME_STEPS,
    parameter int SPIKE_W    = DEF_SPIKE_W,
    parameter int WEIGHT_W   = DEF_WEIGHT_W,
    parameter int LANE_W     = DEF_LANE_W
) (
    input  logic                           s_clk,
    input  logic                           s_rst,
    input  logic                           w_load_valid,
    input  logic [WEIGHT_W-1:0]            w_load_data,
    output logic                           w_load_ready,
    input  logic                           w_swap,
    output logic                           w_active_ok,
    input  logic                           in_valid,
    input  logic [TIME_STEPS*SPIKE_W-1:0]  in_data,
    output logic                           out_valid,
    output logic [TIME_STEPS*SPIKE_W-1:0]  out_data,
    input  logic [TIME_STEPS*LANE_W-1:0]   in_psum,
    output logic                           out_psum_valid,
    output logic [TIME_STEPS*LANE_W-1:0]   out_psum
);

    bank_state_e                  state_q, state_d;
    logic [WEIGHT_W-1:0]          shadow_q, shadow_d;
    logic [WEIGHT_W-1:0]          active_q, active_d;
    logic                         active_ok_q, active_ok_d;
    logic                         out_valid_q, out_valid_d;
    logic [TIME_STEPS*SPIKE_W-1:0] out_data_q, out_data_d;
    logic                         psum_valid_q, psum_valid_d;

    // Weight bank handshake. A swap in SH_FULL wins over a simultaneous load,
    // which is dropped because the FSM only accepts loads in SH_EMPTY.
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        active_d    = active_q;
        active_ok_d = active_ok_q;
        case (state_q)
            SH_EMPTY: begin
                if (w_load_valid) begin
                    shadow_d = w_load_data;
                    state_d  = SH_FULL;
                end
            end
            SH_FULL: begin
                if (w_swap) begin
                    active_d    = shadow_q;
                    active_ok_d = 1'b1;
                    state_d     = SH_EMPTY;
                end
            end
            default: state_d = SH_EMPTY;
        endcase
    end

    always_comb begin
        out_valid_d  = in_valid;
        out_data_d   = in_data;
        psum_valid_d = out_valid_q;
    end

    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            state_q      <= SH_EMPTY;
            shadow_q     <= '0;
            active_q     <= '0;
            active_ok_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            psum_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            active_ok_q  <= active_ok_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            psum_valid_q <= psum_valid_d;
        end
    end

    // Ready is masked during reset so no output claims readiness while the
    // block is being held in reset; loads are ignored then anyway.
    assign w_load_ready   = (state_q == SH_EMPTY) && !s_rst;
    assign w_active_ok    = active_ok_q;
    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign out_psum_valid = psum_valid_q;

    // Products are captured with the beat (using active_q before any swap on
    // the same edge); sums are registered when the beat is forwarded.
    genvar gi;
    generate
        for (gi = 0; gi < TIME_STEPS; gi++) begin : g_lane
            systolic_lane_mac #(
                .SPIKE_W  (SPIKE_W),
                .WEIGHT_W (WEIGHT_W),
                .LANE_W   (LANE_W)
            ) u_lane_mac (
                .s_clk    (s_clk),
                .s_rst    (s_rst),
                .capture  (in_valid),
                .spike    (in_data[lane_lsb(gi, SPIKE_W) +: SPIKE_W]),
                .weight   (active_q),
                .update   (out_valid_q),
                .psum_in  (in_psum[lane_lsb(gi, LANE_W) +: LANE_W]),
                .psum_out (out_psum[lane_lsb(gi, LANE_W) +: LANE_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_systolic_pe_param.sv
module tb_systolic_pe_param;

    localparam int TS = 4;
    localparam int SW = 2;
    localparam int WW = 8;
    localparam int LW = 20;

    logic              s_clk;
    logic              s_rst;
    logic              w_load_valid;
    logic [WW-1:0]     w_load_data;
    logic              w_load_ready;
    logic              w_swap;
    logic              w_active_ok;
    logic              in_valid;
    logic [TS*SW-1:0]  in_data;
    logic              out_valid;
    logic [TS*SW-1:0]  out_data;
    logic [TS*LW-1:0]  in_psum;
    logic              out_psum_valid;
    logic [TS*LW-1:0]  out_psum;

    int errors = 0;
    int checks = 0;

    systolic_pe_param #(
        .TIME_STEPS (TS),
        .SPIKE_W    (SW),
        .WEIGHT_W   (WW),
        .LANE_W     (LW)
    ) dut (
        .s_clk          (s_clk),
        .s_rst          (s_rst),
        .w_load_valid   (w_load_valid),
        .w_load_data    (w_load_data),
        .w_load_ready   (w_load_ready),
        .w_swap         (w_swap),
        .w_active_ok    (w_active_ok),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .in_psum        (in_psum),
        .out_psum_valid (out_psum_valid),
        .out_psum       (out_psum)
    );

    initial s_clk = 1'b0;
    always #5 s_clk = ~s_clk;

    function automatic logic [TS*SW-1:0] pack_spk(input int s0, input int s1, input int s2, input int s3);
        logic [TS*SW-1:0] r;
        r[1:0] = 2'(s0);
        r[3:2] = 2'(s1);
        r[5:4] = 2'(s2);
        r[7:6] = 2'(s3);
        return r;
    endfunction

    function automatic logic [TS*LW-1:0] pack_psum(input int a0, input int a1, input int a2, input int a3);
        logic [TS*LW-1:0] r;
        r[19:0]  = 20'(a0);
        r[39:20] = 20'(a1);
        r[59:40] = 20'(a2);
        r[79:60] = 20'(a3);
        return r;
    endfunction

    // Sample 1 time unit after the rising edge; inputs changed here are
    // stable well before the next edge.
    task automatic tick();
        @(posedge s_clk);
        #1;
    endtask

    task automatic load_weight(input int w);
        w_load_valid = 1'b1;
        w_load_data  = WW'(w);
        tick();
        w_load_valid = 1'b0;
        w_load_data  = '0;
    endtask

    task automatic do_swap();
        w_swap = 1'b1;
        tick();
        w_swap = 1'b0;
    endtask

    // One isolated beat: spikes on the first edge, in_psum on the second.
    task automatic run_beat(input logic [TS*SW-1:0] spk, input logic [TS*LW-1:0] ps,
                            output logic [TS*LW-1:0] res, output logic vld);
        in_valid = 1'b1;
        in_data  = spk;
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        in_psum  = ps;
        tick();
        res     = out_psum;
        vld     = out_psum_valid;
        in_psum = '0;
        $display("beat spk=%h in_psum=%h -> out_psum=%h valid=%0b", spk, ps, res, vld);
    endtask

    task automatic test_reset();
        s_rst = 1'b1;
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        checks++; if (out_psum_valid !== 1'b0) begin errors++; $display("FAIL reset_psum_valid: got %0b expected 0", out_psum_valid); end
        checks++; if (out_psum !== '0) begin errors++; $display("FAIL reset_out_psum: got %h expected 0", out_psum); end
        checks++; if (w_active_ok !== 1'b0) begin errors++; $display("FAIL reset_active_ok: got %0b expected 0", w_active_ok); end
        checks++; if (w_load_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_reset: got %0b expected 0", w_load_ready); end
        s_rst = 1'b0;
        tick();
        checks++; if (w_load_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %0b expected 1", w_load_ready); end
        $display("reset done");
    endtask

    task automatic test_bank_handshake();
        logic [TS*LW-1:0] exp;
        load_weight(5);
        checks++; if (w_load_ready !== 1'b0) begin errors++; $display("FAIL hs_ready_full: got %0b expected 0", w_load_ready); end
        checks++; if (w_active_ok !== 1'b0) begin errors++; $display("FAIL hs_ok_before_swap: got %0b expected 0", w_active_ok); end
        do_swap();
        checks++; if (w_active_ok !== 1'b1) begin errors++; $display("FAIL hs_ok_after_swap: got %0b expected 1", w_active_ok); end
        checks++; if (w_load_ready !== 1'b1) begin errors++; $display("FAIL hs_ready_after_swap: got %0b expected 1", w_load_ready); end
        in_valid = 1'b1;
        in_data  = pack_spk(0, 1, 2, 3);
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hs_out_valid: got %0b expected 1", out_valid); end
        checks++; if (out_data !== pack_spk(0, 1, 2, 3)) begin errors++; $display("FAIL hs_out_data: got %h expected %h", out_data, pack_spk(0, 1, 2, 3)); end
        checks++; if (out_psum_valid !== 1'b0) begin errors++; $display("FAIL hs_psum_early: got %0b expected 0", out_psum_valid); end
        in_psum = pack_psum(7, -20, 0, 1000);
        tick();
        in_psum = '0;
        exp = pack_psum(7, -15, 10, 1015);
        checks++; if (out_psum_valid !== 1'b1) begin errors++; $display("FAIL hs_psum_valid: got %0b expected 1", out_psum_valid); end
        checks++; if (out_psum !== exp) begin errors++; $display("FAIL hs_psum: got %h expected %h", out_psum, exp); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hs_out_valid_drop: got %0b expected 0", out_valid); end
        tick();
        checks++; if (out_psum_valid !== 1'b0) begin errors++; $display("FAIL hs_psum_valid_drop: got %0b expected 0", out_psum_valid); end
        checks++; if (out_psum !== exp) begin errors++; $display("FAIL hs_psum_hold: got %h expected %h", out_psum, exp); end
        $display("handshake beat out_psum=%h", out_psum);
    endtask

    task automatic test_ping_pong();
        logic [TS*LW-1:0] exp1, exp2;
        load_weight(-7);
        do_swap();
        load_weight(9);
        checks++; if (w_load_ready !== 1'b0) begin errors++; $display("FAIL pp_ready_full: got %0b expected 0", w_load_ready); end
        // Beat 1 and the swap share an edge: the captured product keeps -7.
        in_valid = 1'b1;
        in_data  = pack_spk(1, 2, 3, 0);
        w_swap   = 1'b1;
        tick();
        w_swap   = 1'b0;
        checks++; if (w_load_ready !== 1'b1) begin errors++; $display("FAIL pp_ready_rise: got %0b expected 1", w_load_ready); end
        in_data  = pack_spk(3, 0, 1, 2);
        in_psum  = '0;
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        in_psum  = pack_psum(100, 100, 100, 100);
        exp1 = pack_psum(-7, -14, -21, 0);
        checks++; if (out_psum !== exp1) begin errors++; $display("FAIL pp_first_old_weight: got %h expected %h", out_psum, exp1); end
        tick();
        in_psum = '0;
        exp2 = pack_psum(127, 100, 109, 118);
        checks++; if (out_psum_valid !== 1'b1) begin errors++; $display("FAIL pp_second_valid: got %0b expected 1", out_psum_valid); end
        checks++; if (out_psum !== exp2) begin errors++; $display("FAIL pp_second_new_weight: got %h expected %h", out_psum, exp2); end
        $display("ping-pong results %h then %h", exp1, out_psum);
    endtask

    task automatic test_ignored();
        logic [TS*LW-1:0] res;
        logic vld;
        // Active is 9, state SH_EMPTY: a swap must do nothing.
        do_swap();
        checks++; if (w_active_ok !== 1'b1) begin errors++; $display("FAIL ign_swap_ok: got %0b expected 1", w_active_ok); end
        checks++; if (w_load_ready !== 1'b1) begin errors++; $display("FAIL ign_swap_ready: got %0b expected 1", w_load_ready); end
        run_beat(pack_spk(1, 1, 1, 1), '0, res, vld);
        checks++; if (res !== pack_psum(9, 9, 9, 9)) begin errors++; $display("FAIL ign_swap_active: got %h expected %h", res, pack_psum(9, 9, 9, 9)); end
        load_weight(4);
        load_weight(11);
        checks++; if (w_load_ready !== 1'b0) begin errors++; $display("FAIL ign_load_ready: got %0b expected 0", w_load_ready); end
        do_swap();
        run_beat(pack_spk(1, 2, 1, 1), pack_psum(0, 1, 0, 0), res, vld);
        checks++; if (res !== pack_psum(4, 9, 4, 4)) begin errors++; $display("FAIL ign_load_shadow: got %h expected %h", res, pack_psum(4, 9, 4, 4)); end
    endtask

    task automatic test_simul_swap_load();
        logic [TS*LW-1:0] res;
        logic vld;
        load_weight(6);
        w_swap       = 1'b1;
        w_load_valid = 1'b1;
        w_load_data  = 8'd33;
        tick();
        w_swap       = 1'b0;
        w_load_valid = 1'b0;
        w_load_data  = '0;
        checks++; if (w_load_ready !== 1'b1) begin errors++; $display("FAIL sim_state_empty: got ready %0b expected 1", w_load_ready); end
        // A stray swap now is in SH_EMPTY and must not pick up the dropped 33.
        do_swap();
        run_beat(pack_spk(1, 1, 1, 1), '0, res, vld);
        checks++; if (res !== pack_psum(6, 6, 6, 6)) begin errors++; $display("FAIL sim_swap_applied: got %h expected %h", res, pack_psum(6, 6, 6, 6)); end
    endtask

    task automatic test_overflow();
        logic [TS*LW-1:0] res, exp;
        logic vld;
        int pos_exp, neg_exp;
`ifdef SYSTOLIC_PE_SAT_EN
        pos_exp = 524287;
        neg_exp = -524288;
`else
        pos_exp = -524288 + 380;
        neg_exp = 523904;
`endif
        set_weight: begin
            load_weight(127);
            do_swap();
        end
        run_beat(pack_spk(3, 3, 3, 3), pack_psum(524287, 0, -1000, 524287), res, vld);
        exp = pack_psum(pos_exp, 381, -619, pos_exp);
        checks++; if (res !== exp) begin errors++; $display("FAIL ovf_positive: got %h expected %h", res, exp); end
        load_weight(-128);
        do_swap();
        run_beat(pack_spk(3, 1, 3, 0), pack_psum(-524288, 0, 384, -524288), res, vld);
        exp = pack_psum(neg_exp, -128, 0, -524288);
        checks++; if (res !== exp) begin errors++; $display("FAIL ovf_negative: got %h expected %h", res, exp); end
    endtask

    task automatic test_reset_midstream();
        logic [TS*LW-1:0] res;
        logic vld;
        load_weight(2);
        do_swap();
        load_weight(50);
        in_valid = 1'b1;
        in_data  = pack_spk(3, 3, 3, 3);
        tick();
        // Reset lands with a product in flight and a new beat, swap and load.
        s_rst        = 1'b1;
        w_swap       = 1'b1;
        w_load_valid = 1'b1;
        w_load_data  = 8'd77;
        in_psum      = pack_psum(1, 1, 1, 1);
        tick();
        s_rst        = 1'b0;
        w_swap       = 1'b0;
        w_load_valid = 1'b0;
        w_load_data  = '0;
        in_valid     = 1'b0;
        in_data      = '0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %0b expected 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL mid_out_data: got %h expected 0", out_data); end
        checks++; if (out_psum_valid !== 1'b0) begin errors++; $display("FAIL mid_psum_valid: got %0b expected 0", out_psum_valid); end
        checks++; if (out_psum !== '0) begin errors++; $display("FAIL mid_out_psum: got %h expected 0", out_psum); end
        checks++; if (w_active_ok !== 1'b0) begin errors++; $display("FAIL mid_active_ok: got %0b expected 0", w_active_ok); end
        tick();
        in_psum = '0;
        checks++; if (out_psum_valid !== 1'b0) begin errors++; $display("FAIL mid_no_stale_valid: got %0b expected 0", out_psum_valid); end
        checks++; if (out_psum !== '0) begin errors++; $display("FAIL mid_no_stale_psum: got %h expected 0", out_psum); end
        checks++; if (w_load_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %0b expected 1", w_load_ready); end
        // Active bank was cleared: the beat adds nothing to in_psum.
        run_beat(pack_spk(3, 2, 1, 3), pack_psum(55, 55, 55, 55), res, vld);
        checks++; if (res !== pack_psum(55, 55, 55, 55)) begin errors++; $display("FAIL mid_active_cleared: got %h expected %h", res, pack_psum(55, 55, 55, 55)); end
        load_weight(3);
        do_swap();
        checks++; if (w_active_ok !== 1'b1) begin errors++; $display("FAIL mid_reload_ok: got %0b expected 1", w_active_ok); end
        run_beat(pack_spk(1, 2, 3, 0), pack_psum(10, 0, -10, 0), res, vld);
        checks++; if (vld !== 1'b1) begin errors++; $display("FAIL mid_fresh_valid: got %0b expected 1", vld); end
        checks++; if (res !== pack_psum(13, 6, -1, 0)) begin errors++; $display("FAIL mid_fresh_result: got %h expected %h", res, pack_psum(13, 6, -1, 0)); end
    endtask

    initial begin
        s_rst        = 1'b1;
        w_load_valid = 1'b0;
        w_load_data  = '0;
        w_swap       = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        in_psum      = '0;
        test_reset();
        test_bank_handshake();
        test_ping_pong();
        test_ignored();
        test_simul_swap_load();
        test_overflow();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/systolic_pe_param.md
SYSTOLIC_PE_PARAM -- requirements
Module: systolic_pe_param

Interface
REQ-001 SHALL have parameter TIME_STEPS, default 4, the number of independent time-step lanes.
REQ-002 SHALL have parameter SPIKE_W, default 2, the unsigned activation width per lane.
REQ-003 SHALL have parameter WEIGHT_W, default 8, the signed weight width.
REQ-004 SHALL have parameter LANE_W, default 20, the signed partial-sum width per lane.
REQ-005 SHALL have port s_clk, input, 1 bit: the single clock; reset is synchronous and active-high.
REQ-006 SHALL have port s_rst, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL have port w_load_valid, input, 1 bit: weight-write strobe into the shadow bank.
REQ-008 SHALL have port w_load_data, input, WEIGHT_W bits: signed weight.
REQ-009 SHALL have port w_load_ready, output, 1 bit: high while the shadow bank is empty.
REQ-010 SHALL have port w_swap, input, 1 bit: request to promote the shadow bank to active.
REQ-011 SHALL have port w_active_ok, output, 1 bit: high once the active bank holds a loaded weight.
REQ-012 SHALL have port in_valid, input, 1 bit, and port in_data, input, TIME_STEPS*SPIKE_W bits, packed with lane t at bits [t*SPIKE_W +: SPIKE_W].
REQ-013 SHALL have port out_valid, output, 1 bit, and port out_data, output, TIME_STEPS*SPIKE_W bits: the activation forwarded to the right-hand neighbour.
REQ-014 SHALL have port in_psum, input, TIME_STEPS*LANE_W bits: the partial sum from the PE above.
REQ-015 SHALL have port out_psum_valid, output, 1 bit, and port out_psum, output, TIME_STEPS*LANE_W bits.

Function
REQ-016 out_valid and out_data SHALL equal in_valid and in_data delayed by exactly 1 cycle.
REQ-017 Per lane, a product register SHALL capture the unsigned spike value times the active weight, WEIGHT_W+SPIKE_W bits signed, on each cycle with in_valid high, and SHALL hold otherwise.
REQ-018 The multiply SHALL be built from shift-and-add terms, one per spike bit, with no DSP inference.
REQ-019 in_psum SHALL be sampled in the cycle where out_valid is high.
REQ-020 On that same edge, each lane of out_psum SHALL register the sign-extended product plus the in_psum lane, so psum latency is 2 cycles from in_valid.
REQ-021 out_psum_valid SHALL equal out_valid delayed by 1 cycle; out_psum SHALL hold when not updated.
REQ-022 The weight bank state machine SHALL have states SH_EMPTY and SH_FULL.
REQ-023 In SH_EMPTY, w_load_valid SHALL write the shadow bank and transition to SH_FULL.
REQ-024 In SH_FULL, w_swap SHALL copy shadow to active, set w_active_ok, and return to SH_EMPTY.
REQ-025 w_load_ready SHALL be 1 in SH_EMPTY and 0 in SH_FULL.
REQ-026 w_load_valid SHALL be ignored in SH_FULL.
REQ-027 w_swap SHALL be ignored in SH_EMPTY, and the active weight SHALL be unchanged.
REQ-028 When w_swap and w_load_valid are both high in SH_FULL, the swap SHALL take effect and the load SHALL be dropped.
REQ-029 A swap SHALL affect products captured from the next edge onward; in-flight products SHALL keep the old weight.

Reset
REQ-030 On s_rst, at the next edge: all outputs 0, both banks 0, product registers 0, state SH_EMPTY, w_active_ok 0.
REQ-031 Reset SHALL override any simultaneous load, swap or valid, including mid-stream; the first post-reset output SHALL reflect only post-reset inputs.

Configuration
REQ-032 With SYSTOLIC_PE_SAT_EN defined, each lane sum SHALL saturate to [-2^(LANE_W-1), 2^(LANE_W-1)-1].
REQ-033 With SYSTOLIC_PE_SAT_EN undefined, each lane sum SHALL wrap modulo 2^LANE_W.

Structure
REQ-034 The shared package SHALL hold the default TIME_STEPS, SPIKE_W, WEIGHT_W and LANE_W constants, the packed-lane index helper, and the bank-state typedef.
REQ-035 One sub-module, systolic_lane_mac, SHALL implement the per-lane product register and add/saturate stage and be instantiated TIME_STEPS times.

Verification
REQ-036 Bank handshake: load 5, swap, then drive lanes {3,2,1,0} -> 2 cycles later out_psum lanes = in_psum + {15,10,5,0}.
REQ-037 Ping-pong: with active -7 and shadow 9 loaded, send one beat, swap, send one beat -> first result uses -7, second uses 9; w_load_ready rises after the swap.
REQ-038 Ignored events: a load in SH_FULL leaves the shadow unchanged; a swap in SH_EMPTY leaves the active weight unchanged and w_active_ok unchanged.
REQ-039 Simultaneous swap and load in SH_FULL -> swap applied, load dropped, state SH_EMPTY.
REQ-040 Overflow: weight 127, spike 3, in_psum lane 2^19-1 -> with SAT_EN the lane reads 524287; without SAT_EN it wraps to -524288+380.
REQ-041 Reset mid-stream: assert s_rst with in_valid high -> all outputs 0 next cycle, w_active_ok 0; a fresh load, swap and beat produce the correct result.
